pll_lock_supervisor: RTL
========================

# pll_lock_supervisor

Sequences the bring-up and recovery of the board PLL (48 MHz reference in, 40 MHz pixel clock out). It drives the PLL reset, requires lock to stay stable before declaring the clock usable, and retries a bounded number of times before flagging a fault. It runs on the free-running 48 MHz reference clock. `ready` is the qualifier that the pixel-domain reset synchronizer consumes.

## Interface
Parameters:
- `RST_CYCLES`, 16: width of each PLL reset pulse, in clock cycles (≥1).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before `ready` (≥1).
- `LOCK_TIMEOUT_CYCLES`, 48000: maximum cycles to wait for lock after a reset pulse (1 ms at 48 MHz).
- `MAX_RETRIES`, 3: reset retries after the initial attempt before declaring a fault.

Ports:
- `clock` in 1: 48 MHz reference clock (same net feeding PLL CLKI).
- `reset` in 1: asynchronous, active-high.
- `pll_locked` in 1: raw PLL LOCK. Asynchronous to `clock`; synchronized internally by 2 flops.
- `restart` in 1: single-cycle request to restart the sequence from scratch.
- `pll_reset` out 1: drives PLL RST.
- `ready` out 1: output clock is locked and stable.
- `lock_lost` out 1: one-cycle pulse when lock drops while in RUN.
- `fault` out 1: retries exhausted; remains set until `reset` or `restart`.
- `retry_count` out $clog2(MAX_RETRIES+1): retries consumed in the current bring-up.

## Operation
- Internal counter width is $clog2 of the largest parameter plus 1. A single counter is shared across states and cleared on every state change.
- `lock_s` is the 2-flop synchronized `pll_locked`. Both flops reset to 0.
- States:
  - RESET_PLL: `pll_reset`=1. After exactly RST_CYCLES cycles → WAIT_LOCK.
  - WAIT_LOCK: `pll_reset`=0.
    - If `lock_s`=1 → STABILIZE.
    - Otherwise, when the counter reaches LOCK_TIMEOUT_CYCLES-1: if `retry_count`==MAX_RETRIES → FAULT; else increment `retry_count` → RESET_PLL.
  - STABILIZE: `pll_reset`=0.
    - If `lock_s`=0 → WAIT_LOCK with a fresh timeout; `retry_count` unchanged.
    - When the counter reaches LOCK_STABLE_CYCLES-1 with `lock_s`=1 → RUN.
  - RUN: `ready`=1, `retry_count` cleared to 0.
    - If `lock_s`=0: pulse `lock_lost` for one cycle, drop `ready`, → RESET_PLL.
  - FAULT: `pll_reset`=1 and `fault`=1, held indefinitely. `lock_s` is ignored.
- `restart`=1 in any state has priority over all other transitions: → RESET_PLL, `retry_count`=0, `fault`=0, `ready`=0.
- If lock loss and `restart` coincide in RUN, `restart` wins and `lock_lost` is not pulsed.
- A timeout and `lock_s` rising in the same cycle in WAIT_LOCK: lock wins → STABILIZE.
- All outputs are registered or decoded from registered state only; no combinational path from `pll_locked` to any output.

## Timing
- Reset values while `reset`=1, taking effect asynchronously:
  - state=RESET_PLL, counter=0.
  - `pll_reset`=1, `ready`=0, `lock_lost`=0, `fault`=0, `retry_count`=0.
- After `reset` deasserts, `pll_reset` stays high for exactly RST_CYCLES rising edges.
- Lock latency:
  - A `pll_locked` rise is sampled at edge k; `lock_s`=1 after edge k+1; STABILIZE after edge k+2.
  - `ready`=1 after edge k+2+LOCK_STABLE_CYCLES, provided lock holds.
- Lock-loss latency: a drop sampled at edge k gives `lock_lost`=1, `ready`=0 and `pll_reset`=1 after edge k+2. `lock_lost` is high for exactly one cycle.
- Worst-case time to FAULT from reset: (MAX_RETRIES+1)×(RST_CYCLES+LOCK_TIMEOUT_CYCLES) cycles.
- Reset mid-operation: an asynchronous `reset` at any point returns all outputs to their reset values immediately.

## Test plan
All scenarios use RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
- Clean bring-up: release `reset`; raise `pll_locked` at edge 10 and hold → `pll_reset` high for edges 1-4; `ready` rises after edge 20; `retry_count`=0; `lock_lost` never pulses.
- Glitchy lock: `pll_locked` high 5 cycles, low 3, then high → STABILIZE aborts back to WAIT_LOCK with no retry consumed; `ready` rises 10 cycles after the final rise.
- Retry then success: `pll_locked` low through the first timeout → second `pll_reset` pulse of 4 cycles and `retry_count`=1. Lock during the second wait → `ready`=1 and `retry_count` returns to 0.
- Exhaustion: `pll_locked` held low → three reset pulses total; `fault`=1 after 3×36 cycles; `pll_reset` stays 1; later lock activity is ignored.
- Lock loss in RUN: drop `pll_locked` for 1 cycle → one-cycle `lock_lost` 2 cycles later, `ready`=0, 4-cycle `pll_reset` pulse, then the normal re-lock sequence.
- `restart` priority: assert `restart` in FAULT and, separately, in the same cycle as a RUN lock loss → RESET_PLL, `fault`=0, `retry_count`=0, no `lock_lost` pulse. Async `reset` mid-STABILIZE → all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up/recovery sequencer: pulses PLL reset, qualifies a stable lock,
// retries a bounded number of times and latches a fault when retries run out.
module pll_lock_supervisor #(
  parameter int RST_CYCLES          = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 48000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               pll_locked,
  input  logic                               restart,
  output logic                               pll_reset,
  output logic                               ready,
  output logic                               lock_lost,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

  localparam int MAX_A = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_B = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_P = (MAX_B > MAX_RETRIES) ? MAX_B : MAX_RETRIES;
  localparam int CW    = $clog2(MAX_P) + 1;
  localparam int RW    = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          sync_meta;
  logic          lock_s;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      sync_meta <= pll_locked;
      lock_s    <= sync_meta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_RESET_PLL;
      count       <= '0;
      pll_reset   <= 1'b1;
      ready       <= 1'b0;
      lock_lost   <= 1'b0;
      fault       <= 1'b0;
      retry_count <= '0;
    end else begin
      lock_lost <= 1'b0;
      if (restart) begin
        // Restart overrides every state, including a coincident lock loss.
        state       <= S_RESET_PLL;
        count       <= '0;
        pll_reset   <= 1'b1;
        ready       <= 1'b0;
        fault       <= 1'b0;
        retry_count <= '0;
      end else begin
        case (state)
          S_RESET_PLL: begin
            if (count == RST_LAST) begin
              state     <= S_WAIT_LOCK;
              count     <= '0;
              pll_reset <= 1'b0;
            end else begin
              count <= count + CW'(1);
            end
          end

          S_WAIT_LOCK: begin
            if (lock_s) begin
              state <= S_STABILIZE;
              count <= '0;
            end else if (count == TIMEOUT_LAST) begin
              count     <= '0;
              pll_reset <= 1'b1;
              if (retry_count == RETRY_LIMIT) begin
                state <= S_FAULT;
                fault <= 1'b1;
              end else begin
                state       <= S_RESET_PLL;
                retry_count <= retry_count + RW'(1);
              end
            end else begin
              count <= count + CW'(1);
            end
          end

          S_STABILIZE: begin
            // A lock glitch restarts the wait but does not consume a retry.
            if (!lock_s) begin
              state <= S_WAIT_LOCK;
              count <= '0;
            end else if (count == STABLE_LAST) begin
              state       <= S_RUN;
              count       <= '0;
              ready       <= 1'b1;
              retry_count <= '0;
            end else begin
              count <= count + CW'(1);
            end
          end

          S_RUN: begin
            retry_count <= '0;
            if (!lock_s) begin
              state     <= S_RESET_PLL;
              count     <= '0;
              lock_lost <= 1'b1;
              ready     <= 1'b0;
              pll_reset <= 1'b1;
            end
          end

          S_FAULT: begin
            pll_reset <= 1'b1;
            fault     <= 1'b1;
          end

          default: begin
            state     <= S_RESET_PLL;
            count     <= '0;
            pll_reset <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
